// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-RAM access sequencer: funct3 encodings,
// sequencer states, read-latency bound and the access legality rule.
package mem_ctrl_pkg;

  // RISC-V load/store funct3 encodings (the low two bits give the access size)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Largest supported RAM read latency and the width of the WAIT down-counter
  localparam int RD_LAT_MAX = 4;
  localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } seqState_t;

  // True when an access must be rejected: illegal funct3 for the direction,
  // or a half/word access that is not naturally aligned.
  function automatic logic isRejected(input logic isStore,
                                      input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic illegal;
    if (isStore) illegal = (funct3 > F3_W);
    else         illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return illegal
        || ((funct3[1:0] == 2'd1) && lane[0])
        || ((funct3[1:0] == 2'd2) && (lane != 2'd0));
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane logic: merges store data into a read word and
// extracts/extends load results from a read word.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] mergedWord,
  output logic [31:0] loadValue
);

  // Replace only the lanes covered by the store; word stores pass through.
  function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  ln);
    logic [31:0] w;
    w = word;
    case (f3)
      F3_B:    w[{ln, 3'b000} +: 8] = data[7:0];
      F3_H:    if (ln[1]) w[31:16] = data[15:0];
               else       w[15:0]  = data[15:0];
      default: w = data;
    endcase
    return w;
  endfunction

  // Select the addressed lanes and sign- or zero-extend them.
  function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

  assign mergedWord = mergeStore(oldWord, storeData, funct3, lane);
  assign loadValue  = extractLoad(oldWord, funct3, lane);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences core loads/stores onto a single-port word RAM. Word stores write
// directly; byte/half stores read-modify-write; loads read and extend.
module mem_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ,
  input  logic        iWE,
  input  logic [2:0]  iFUNC3,
  input  logic [31:0] iADDR,
  input  logic [31:0] iWDATA,
  output logic        oREADY,
  output logic        oDONE,
  output logic        oMISALIGN,
  output logic [31:0] oRDATA,
  output logic        oRAM_CE,
  output logic        oRAM_WR,
  output logic [31:0] oRAM_ADDR,
  output logic [31:0] oRAM_DATA,
  input  logic [31:0] iRAM_DATA
);

  seqState_t state, nextState;

  logic                 isStoreQ;
  logic [2:0]           funct3Q;
  logic [1:0]           laneQ;
  logic [31:0]          wdataQ;
  logic                 misalignQ;
  logic [LAT_CNT_W-1:0] waitCnt;
  logic                 accept;
  logic                 reqReject;
  logic                 lastWait;
  logic [31:0]          mergedWord;
  logic [31:0]          loadValue;

  assign accept    = iREQ && oREADY;
  assign reqReject = isRejected(iWE, iFUNC3, iADDR[1:0]);
  assign lastWait  = (state == S_WAIT) && (waitCnt == '0);

  mem_lane_unit laneUnit (
    .oldWord    (iRAM_DATA),
    .storeData  (wdataQ),
    .funct3     (funct3Q),
    .lane       (laneQ),
    .mergedWord (mergedWord),
    .loadValue  (loadValue)
  );

  // State register; reset forces IDLE at once so RAM strobes drop asynchronously.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!iRST_N) state <= S_IDLE;
    else         state <= nextState;
  end

  // Next-state decode; the request decision is made from the live inputs in IDLE.
  always_comb begin
    // NOTE: default first so no path leaves nextState unassigned (no latch).
    nextState = state;
    case (state)
      S_IDLE: begin
        if (iREQ) begin
          if (reqReject)                    nextState = S_DONE;
          else if (iWE && iFUNC3 == F3_W)   nextState = S_WR;
          else                              nextState = S_RD;
        end
      end
      S_RD:    nextState = S_WAIT;
      S_WAIT:  if (waitCnt == '0) nextState = isStoreQ ? S_WR : S_DONE;
      S_WR:    nextState = S_DONE;
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Handshake and RAM strobes decoded purely from state.
  always_comb begin
    oREADY  = 1'b0;
    oDONE   = 1'b0;
    oRAM_CE = 1'b0;
    oRAM_WR = 1'b0;
    case (state)
      S_IDLE: oREADY = 1'b1;
      S_RD:   oRAM_CE = 1'b1;
      S_WR: begin
        oRAM_CE = 1'b1;
        oRAM_WR = 1'b1;
      end
      S_DONE: oDONE = 1'b1;
      default: ;
    endcase
  end

  assign oMISALIGN = oDONE && misalignQ;

  // Request capture, WAIT down-counter, read-word merge and load result.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      isStoreQ  <= 1'b0;
      funct3Q   <= 3'd0;
      laneQ     <= 2'd0;
      wdataQ    <= '0;
      misalignQ <= 1'b0;
      waitCnt   <= '0;
      oRDATA    <= '0;
      oRAM_ADDR <= '0;
      oRAM_DATA <= '0;
    end else begin
      if (accept) begin
        isStoreQ  <= iWE;
        funct3Q   <= iFUNC3;
        laneQ     <= iADDR[1:0];
        wdataQ    <= iWDATA;
        misalignQ <= reqReject;
        oRAM_ADDR <= {iADDR[31:2], 2'b00};
        // Word stores write straight from here; RMW stores overwrite it later.
        if (iWE) oRAM_DATA <= iWDATA;
      end
      if (state == S_RD)       waitCnt <= LAT_CNT_W'(RD_LAT - 1);
      else if (state == S_WAIT && waitCnt != '0) waitCnt <= waitCnt - 1'b1;
      // The read word is valid in the last WAIT cycle.
      if (lastWait) begin
        if (isStoreQ) oRAM_DATA <= mergedWord;
        else          oRDATA    <= loadValue;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: two instances (RD_LAT = 1 and 3) share the
// same stimulus, each with its own latency-accurate RAM model.
module tb_mem_access_sequencer;
  import mem_ctrl_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [31:0] POISON = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  req;
  logic        reqWe;
  logic [2:0]  reqF3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;

  logic [1:0]  ready, done, mis, ce, wr;
  logic [31:0] rdata     [2];
  logic [31:0] ramAddr   [2];
  logic [31:0] ramWdata  [2];
  logic [31:0] ramRdata  [2];

  // RAM models
  logic [31:0] mem  [2][256];
  logic [31:0] pipe [2][4];
  int          wrCount [2] = '{0, 0};
  int          ceCount [2] = '{0, 0};
  logic [31:0] wrAddr  [2];
  logic [31:0] wrData  [2];
  logic        plEn = 1'b0;
  logic [7:0]  plIdx = 8'd0;
  logic [31:0] plWord = 32'd0;

  // Reference model state
  logic [31:0] refMem [256];
  logic [31:0] expRdata;

  int checkCount = 0;
  int passCount  = 0;

  // Per-access observations
  int          doneLat   [2];
  logic        doneMis   [2];
  logic [31:0] doneRdata [2];
  int          wrDelta   [2];
  int          ceDelta   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int LAT = (g == 0) ? LAT_A : LAT_B;
    mem_access_sequencer #(.RD_LAT(LAT)) dut (
      .iCLK      (clk),
      .iRST_N    (rstN),
      .iREQ      (req[g]),
      .iWE       (reqWe),
      .iFUNC3    (reqF3),
      .iADDR     (reqAddr),
      .iWDATA    (reqWdata),
      .oREADY    (ready[g]),
      .oDONE     (done[g]),
      .oMISALIGN (mis[g]),
      .oRDATA    (rdata[g]),
      .oRAM_CE   (ce[g]),
      .oRAM_WR   (wr[g]),
      .oRAM_ADDR (ramAddr[g]),
      .oRAM_DATA (ramWdata[g]),
      .iRAM_DATA (ramRdata[g])
    );
    assign ramRdata[g] = pipe[g][LAT-1];
  end

  // RAM model: writes land at the edge, reads emerge after the instance latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (plEn) begin
        mem[i][plIdx] <= plWord;
      end else if (ce[i] && wr[i]) begin
        mem[i][ramAddr[i][9:2]] <= ramWdata[i];
        wrCount[i] <= wrCount[i] + 1;
        wrAddr[i]  <= ramAddr[i];
        wrData[i]  <= ramWdata[i];
      end
      if (ce[i]) ceCount[i] <= ceCount[i] + 1;
      pipe[i][0] <= (ce[i] && !wr[i]) ? mem[i][ramAddr[i][9:2]] : POISON;
      for (int s = 1; s < 4; s++) pipe[i][s] <= pipe[i][s-1];
    end
  end

  function automatic int latOf(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    plEn   = 1'b1;
    plIdx  = addr[9:2];
    plWord = w;
    refMem[addr[9:2]] = w;
    @(posedge clk);
    @(negedge clk);
    plEn = 1'b0;
  endtask

  // Issue one access to both instances and record completion timing/results.
  task automatic runAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold);
    int wc [2];
    int cc [2];
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready_idle_%0d", i), ready[i], 1'b1);
      wc[i] = wrCount[i];
      cc[i] = ceCount[i];
      doneLat[i] = 0;
      doneMis[i] = 1'b0;
      doneRdata[i] = '0;
    end
    reqWe = we; reqF3 = f3; reqAddr = addr; reqWdata = wdata;
    req = 2'b11;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!hold) req[i] = 1'b0;
        if (doneLat[i] == 0 && done[i]) begin
          doneLat[i]   = k;
          doneMis[i]   = mis[i];
          doneRdata[i] = rdata[i];
          req[i]       = 1'b0;
        end
      end
      if (doneLat[0] != 0 && doneLat[1] != 0) break;
    end
    req = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      wrDelta[i] = wrCount[i] - wc[i];
      ceDelta[i] = ceCount[i] - cc[i];
    end
  endtask

  task automatic verify(input string tag, input int latL1, input bit usesRead, input bit expMis,
                        input bit expWrite, input logic [31:0] expWrAddr,
                        input logic [31:0] expWrData, input logic [31:0] expRd);
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = latL1 + (usesRead ? latOf(i) - 1 : 0);
      check($sformatf("%s_lat_%0d", tag, i), doneLat[i], lat);
      check($sformatf("%s_mis_%0d", tag, i), doneMis[i], expMis);
      check($sformatf("%s_rdata_%0d", tag, i), doneRdata[i], expRd);
      check($sformatf("%s_nwr_%0d", tag, i), wrDelta[i], expWrite ? 1 : 0);
      check($sformatf("%s_nce_%0d", tag, i), ceDelta[i], (usesRead ? 1 : 0) + (expWrite ? 1 : 0));
      if (expWrite) begin
        check($sformatf("%s_wraddr_%0d", tag, i), wrAddr[i], expWrAddr);
        check($sformatf("%s_wrdata_%0d", tag, i), wrData[i], expWrData);
      end
    end
  endtask

  // Behavioural model: byte arrays and arithmetic extension over refMem.
  task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output int latL1, output bit usesRead,
                             output bit rej, output bit doesWrite, output logic [31:0] wrWord);
    int size, off;
    logic [31:0] word, val, mask;
    logic [7:0]  bytes [4];
    size = 1 << f3[1:0];
    off  = int'(addr[1:0]);
    word = refMem[addr[9:2]];
    rej  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    if (!rej && (off % size) != 0) rej = 1'b1;
    usesRead = 1'b0; doesWrite = 1'b0; wrWord = '0; latL1 = 1;
    if (rej) begin
      latL1 = 1;
    end else if (we) begin
      for (int b = 0; b < 4; b++) bytes[b] = word[8*b +: 8];
      for (int j = 0; j < size; j++) bytes[off + j] = wdata[8*j +: 8];
      wrWord = {bytes[3], bytes[2], bytes[1], bytes[0]};
      refMem[addr[9:2]] = wrWord;
      doesWrite = 1'b1;
      usesRead  = (size != 4);
      latL1     = usesRead ? 4 : 2;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*size)) - 32'h1;
      val  = (word >> (8*off)) & mask;
      if (!f3[2] && size < 4 && val >= (32'h1 << (8*size - 1)))
        val = val - (32'h1 << (8*size));
      expRdata = val;
      usesRead = 1'b1;
      latL1    = 3;
    end
  endtask

  // Start an SB, then pull reset after `stall` cycles of the access.
  task automatic resetMidAccess(input int stall, input string tag);
    int wc [2];
    preload(32'h200, 32'h1122_3344);
    for (int i = 0; i < 2; i++) wc[i] = wrCount[i];
    reqWe = 1'b1; reqF3 = F3_B; reqAddr = 32'h202; reqWdata = 32'hAA;
    req = 2'b11;
    @(posedge clk);
    repeat (stall) @(negedge clk);
    req = 2'b00;
    for (int i = 0; i < 2; i++)
      check($sformatf("%s_ce_before_%0d", tag, i), ce[i], (stall == 1) ? 1'b1 : 1'b0);
    rstN = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_ce_async_%0d", tag, i), ce[i], 1'b0);
      check($sformatf("%s_wr_async_%0d", tag, i), wr[i], 1'b0);
      check($sformatf("%s_ready_async_%0d", tag, i), ready[i], 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_nowrite_%0d", tag, i), wrCount[i] - wc[i], 0);
      check($sformatf("%s_memkept_%0d", tag, i), mem[i][8'h80], 32'h1122_3344);
      check($sformatf("%s_ready_%0d", tag, i), ready[i], 1'b1);
      check($sformatf("%s_rdata_%0d", tag, i), rdata[i], 32'h0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] preAddr;
    logic [31:0] preWord;
    int          latL1;
    bit          usesRead;
    bit          expMis;
    bit          expWrite;
    logic [31:0] expWrData;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int latL1;
    bit usesRead, rej, doesWrite, hold;
    logic [31:0] wrWord, addr, wdata;
    logic [2:0]  f3;
    logic        we;

    //           we    f3    addr      wdata          preAddr   preWord        lat rd mis wr  wrData         rdata
    vecs[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h100, 32'h0,         2, 0, 0, 1, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 3'd0, 32'h202, 32'h0000_00AA, 32'h200, 32'h1122_3344, 4, 1, 0, 1, 32'h11AA_3344, 32'h0};
    vecs[2]  = '{1'b1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h200, 32'h1122_3344, 4, 1, 0, 1, 32'hBEEF_3344, 32'h0};
    vecs[3]  = '{1'b1, 3'd0, 32'h201, 32'hFFFF_FF55, 32'h200, 32'h1122_3344, 4, 1, 0, 1, 32'h1122_5544, 32'h0};
    vecs[4]  = '{1'b1, 3'd1, 32'h200, 32'hABCD_CAFE, 32'h200, 32'h1122_3344, 4, 1, 0, 1, 32'h1122_CAFE, 32'h0};
    vecs[5]  = '{1'b1, 3'd4, 32'h200, 32'h1234_5678, 32'h200, 32'h1122_3344, 1, 0, 1, 0, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 3'd0, 32'h203, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'hFFFF_FF80};
    vecs[7]  = '{1'b0, 3'd4, 32'h203, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'h0000_0080};
    vecs[8]  = '{1'b0, 3'd1, 32'h200, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'h0000_017F};
    vecs[9]  = '{1'b0, 3'd5, 32'h202, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'h0000_80F0};
    vecs[10] = '{1'b0, 3'd1, 32'h202, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'hFFFF_80F0};
    vecs[11] = '{1'b0, 3'd0, 32'h200, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'h0000_007F};
    vecs[12] = '{1'b0, 3'd2, 32'h200, 32'h0,         32'h200, 32'h80F0_017F, 3, 1, 0, 0, 32'h0,         32'h80F0_017F};
    vecs[13] = '{1'b0, 3'd2, 32'h102, 32'h0,         32'h100, 32'hDEAD_BEEF, 1, 0, 1, 0, 32'h0,         32'h80F0_017F};
    vecs[14] = '{1'b1, 3'd1, 32'h101, 32'h0000_1234, 32'h100, 32'hDEAD_BEEF, 1, 0, 1, 0, 32'h0,         32'h80F0_017F};
    vecs[15] = '{1'b0, 3'd3, 32'h200, 32'h0,         32'h200, 32'h80F0_017F, 1, 0, 1, 0, 32'h0,         32'h80F0_017F};

    rstN = 1'b0; req = 2'b00; reqWe = 1'b0; reqF3 = 3'd0; reqAddr = '0; reqWdata = '0;
    expRdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready_%0d", i), ready[i], 1'b1);
      check($sformatf("rst_done_%0d", i), done[i], 1'b0);
      check($sformatf("rst_mis_%0d", i), mis[i], 1'b0);
      check($sformatf("rst_rdata_%0d", i), rdata[i], 32'h0);
      check($sformatf("rst_ce_%0d", i), ce[i], 1'b0);
      check($sformatf("rst_wr_%0d", i), wr[i], 1'b0);
      check($sformatf("rst_addr_%0d", i), ramAddr[i], 32'h0);
      check($sformatf("rst_wdata_%0d", i), ramWdata[i], 32'h0);
    end
    rstN = 1'b1;
    @(negedge clk);

    // Directed table; every fourth vector keeps iREQ asserted while busy
    for (int v = 0; v < 16; v++) begin
      preload(vecs[v].preAddr, vecs[v].preWord);
      runAccess(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata, (v % 4) == 1);
      verify($sformatf("vec%0d", v), vecs[v].latL1, vecs[v].usesRead, vecs[v].expMis,
             vecs[v].expWrite, vecs[v].addr & ~32'h3, vecs[v].expWrData, vecs[v].expRdata);
    end

    // Reset during the RD cycle and during WAIT of an SB
    resetMidAccess(1, "rst_rd");
    resetMidAccess(2, "rst_wait");
    expRdata = '0;

    // Randomized accesses against the reference model
    for (int k = 0; k < 256; k++) preload(32'(k) << 2, $urandom);
    for (int n = 0; n < 300; n++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = 32'($urandom_range(0, 1023));
      wdata = $urandom;
      hold  = ($urandom_range(0, 3) == 0);
      modelAccess(we, f3, addr, wdata, latL1, usesRead, rej, doesWrite, wrWord);
      runAccess(we, f3, addr, wdata, hold);
      verify($sformatf("rnd%0d", n), latL1, usesRead, rej, doesWrite,
             addr & ~32'h3, wrWord, expRdata);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
